// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared state encoding, LFSR constants and field indexing for the obstacle engine
package obstacle_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DEAD, WON} state_t;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
   function automatic int fidx(input int row, input int lane, input int lanes);
      return row * lanes + lane;
   endfunction
endpackage

// File: rtl/obstacle_engine_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4), shifts left one step per enable
module lfsr8 import obstacle_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [7:0] q
);
   logic [7:0] r_q;
   assign q = r_q;
   always_ff @(posedge clk) begin
      if (reset) r_q <= LFSR_SEED;
      else if (en) r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
   end
endmodule

// File: rtl/obstacle_engine.sv
// obstacle_engine: scrolling lane field, player movement, collision and score for the game FSM
module obstacle_engine import obstacle_pkg::*; #(
   parameter int TICK_DIV  = 1_000_000,
   parameter int LANES     = 4,
   parameter int ROWS      = 8,
   parameter int WIN_SCORE = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     play,
   input  logic                     btn_left,
   input  logic                     btn_right,
   output logic                     win,
   output logic                     dead,
   output logic [$clog2(LANES)-1:0] player_lane,
   output logic [LANES*ROWS-1:0]    field,
   output logic [7:0]               score
);
   localparam int LW = $clog2(LANES);
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [LW-1:0] LANE_MID = LW'(LANES / 2);
   state_t                r_state;
   logic                  r_win, r_dead, r_prev_l, r_prev_r, r_block;
   logic [LW-1:0]         r_lane;
   logic [LANES*ROWS-1:0] r_field;
   logic [7:0]            r_score;
   logic [CW-1:0]         r_cnt;
   logic [7:0]            w_lfsr;
   logic [LANES-1:0]      w_row0, w_spawn_row;
   logic                  w_left, w_right, w_hit, w_done, w_tick, w_step, w_spawn;
   logic                  w_unused_lfsr;
   assign w_left        = btn_left & ~r_prev_l;
   assign w_right       = btn_right & ~r_prev_r;
   assign w_row0        = r_field[fidx(0, 0, LANES) +: LANES];
   assign w_hit         = w_row0[r_lane];
   assign w_done        = r_score == 8'(WIN_SCORE);
   assign w_tick        = r_state == RUN && r_cnt == CW'(TICK_DIV - 1);
   // a collision or win freezes the field, so the LFSR only steps on real scrolls
   assign w_step        = w_tick & play & ~w_hit & ~w_done;
   assign w_spawn       = ~r_block & w_lfsr[0];
   assign w_spawn_row   = w_spawn ? LANES'(1) << w_lfsr[LW:1] : '0;
   assign w_unused_lfsr = ^w_lfsr[7:LW+1];
   assign win           = r_win;
   assign dead          = r_dead;
   assign player_lane   = r_lane;
   assign field         = r_field;
   assign score         = r_score;
   lfsr8 u_lfsr (.clk(clk), .reset(reset), .en(w_step), .q(w_lfsr));
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_win    <= 1'b0;
         r_dead   <= 1'b0;
         r_field  <= '0;
         r_score  <= '0;
         r_lane   <= LANE_MID;
         r_cnt    <= '0;
         r_block  <= 1'b0;
         r_prev_l <= 1'b0;
         r_prev_r <= 1'b0;
      end else begin
         r_prev_l <= btn_left;
         r_prev_r <= btn_right;
         if (!play) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
            r_dead  <= 1'b0;
            r_field <= '0;
            r_score <= '0;
         end else if (r_state == IDLE) begin
            r_state <= RUN;
            r_field <= '0;
            r_score <= '0;
            r_cnt   <= '0;
            r_block <= 1'b0;
            r_lane  <= LANE_MID;
         end else if (r_state == RUN) begin
            if (w_hit) begin
               r_state <= DEAD;
               r_dead  <= 1'b1;
            end else if (w_done) begin
               r_state <= WON;
               r_win   <= 1'b1;
            end else begin
               r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
               if (w_left && !w_right && r_lane != '0) r_lane <= r_lane - LW'(1);
               else if (w_right && !w_left && r_lane != LW'(LANES - 1)) r_lane <= r_lane + LW'(1);
               if (w_tick) begin
                  r_field <= {w_spawn_row, r_field[LANES*ROWS-1:fidx(1, 0, LANES)]};
                  r_score <= r_score + 8'(|w_row0);
                  r_block <= w_spawn;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_obstacle_engine.sv
// tb_obstacle_engine: randomized and directed checks against a row-list model of the play field
module tb_obstacle_engine;
   localparam int TD = 4, L = 4, R = 4, WS = 3;
   logic          clk = 1'b0, reset = 1'b1, play = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic          win, dead;
   logic [1:0]    player_lane;
   logic [L*R-1:0] field;
   logic [7:0]    score;
   logic [27:0]   dut_out;
   int checks = 0, failures = 0;
   int m_st, m_lane, m_score, m_cnt, m_lfsr;
   int m_rows[R];
   bit m_block, m_win, m_dead, m_pl, m_pr;

   always #5 clk = ~clk;

   obstacle_engine #(.TICK_DIV(TD), .LANES(L), .ROWS(R), .WIN_SCORE(WS)) dut (
      .clk(clk), .reset(reset), .play(play), .btn_left(btn_left), .btn_right(btn_right),
      .win(win), .dead(dead), .player_lane(player_lane), .field(field), .score(score)
   );

   assign dut_out = {win, dead, player_lane, field, score};

   function automatic logic [L*R-1:0] m_field();
      logic [L*R-1:0] f = '0;
      for (int r = 0; r < R; r++) if (m_rows[r] >= 0) f[r*L + m_rows[r]] = 1'b1;
      return f;
   endfunction

   function automatic logic [27:0] m_out();
      return {m_win, m_dead, 2'(m_lane), m_field(), 8'(m_score)};
   endfunction

   // model: each row holds the lane of its obstacle, or -1 when empty
   task automatic model_step();
      bit el, er, tk;
      int fb;
      el = btn_left && !m_pl;
      er = btn_right && !m_pr;
      m_pl = btn_left;
      m_pr = btn_right;
      if (reset) begin
         m_st = 0; m_win = 0; m_dead = 0; m_score = 0; m_lane = L / 2;
         m_cnt = 0; m_lfsr = 'hA5; m_block = 0; m_pl = 0; m_pr = 0;
         for (int r = 0; r < R; r++) m_rows[r] = -1;
      end else if (!play) begin
         m_st = 0; m_win = 0; m_dead = 0; m_score = 0;
         for (int r = 0; r < R; r++) m_rows[r] = -1;
      end else if (m_st == 0) begin
         m_st = 1; m_score = 0; m_cnt = 0; m_block = 0; m_lane = L / 2;
         for (int r = 0; r < R; r++) m_rows[r] = -1;
      end else if (m_st == 1) begin
         if (m_rows[0] == m_lane) begin
            m_st = 2; m_dead = 1;
         end else if (m_score == WS) begin
            m_st = 3; m_win = 1;
         end else begin
            tk = (m_cnt == TD - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (el && !er) m_lane = (m_lane > 0) ? m_lane - 1 : 0;
            if (er && !el) m_lane = (m_lane < L - 1) ? m_lane + 1 : L - 1;
            if (tk) begin
               if (m_rows[0] >= 0) m_score++;
               for (int r = 0; r < R - 1; r++) m_rows[r] = m_rows[r+1];
               if (!m_block && (m_lfsr & 1) != 0) begin
                  m_rows[R-1] = (m_lfsr >> 1) % L;
                  m_block = 1;
               end else begin
                  m_rows[R-1] = -1;
                  m_block = 0;
               end
               fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
               m_lfsr = ((m_lfsr << 1) | fb) & 255;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      reset = 1; play = 0; btn_left = 0; btn_right = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (dut_out !== {2'b00, 2'd2, 16'h0, 8'h0}) begin
            failures++;
            $display("FAIL reset_idle cycle %0d got %h want %h", c, dut_out, {2'b00, 2'd2, 16'h0, 8'h0});
         end
      end
   endtask

   task automatic test_death();
      play = 1;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         checks++;
         if (dut_out !== m_out()) begin
            failures++;
            $display("FAIL model_death cycle %0d got %h want %h", c, dut_out, m_out());
         end
         if (c == 3) begin
            checks++;
            if (field !== 16'h0) begin failures++; $display("FAIL first_tick_early got %h want 0000", field); end
         end
         if (c == 4) begin
            checks++;
            if (field !== 16'h4000) begin failures++; $display("FAIL first_spawn got %h want 4000", field); end
         end
         if (c == 16) begin
            checks++;
            if ({field[2], dead} !== 2'b10) begin failures++; $display("FAIL row0_arrival got %b want 10", {field[2], dead}); end
         end
         if (c == 17) begin
            checks++;
            if ({dead, win} !== 2'b10) begin failures++; $display("FAIL death got dead,win=%b want 10", {dead, win}); end
         end
      end
   endtask

   task automatic test_hold(input string name);
      logic [27:0] snap;
      snap = m_out();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (dut_out !== snap) begin
            failures++;
            $display("FAIL hold_%s cycle %0d got %h want %h", name, c, dut_out, snap);
         end
      end
      play = 0;
      @(negedge clk);
      checks++;
      if ({win, dead, field, score} !== 26'h0) begin
         failures++;
         $display("FAIL drop_clear_%s got %h want 0", name, {win, dead, field, score});
      end
   endtask

   task automatic test_dodge_win();
      bit pressed = 0, done = 0;
      play = 1;
      for (int k = 1; k <= 400 && !done; k++) begin
         @(negedge clk);
         checks++;
         if (dut_out !== m_out()) begin
            failures++;
            $display("FAIL model_dodge cycle %0d got %h want %h", k, dut_out, m_out());
         end
         btn_left = 0; btn_right = 0;
         if (k == 1 || k == 3) btn_right = 1;
         else if (k == 4) begin
            checks++;
            if (player_lane !== 2'd3) begin failures++; $display("FAIL right_saturate got %0d want 3", player_lane); end
         end else if (k > 4 && m_st == 1 && !pressed && m_rows[1] == m_lane) begin
            if (m_lane > 0) btn_left = 1;
            else btn_right = 1;
         end
         pressed = btn_left | btn_right;
         if (m_win || m_dead) done = 1;
      end
      btn_left = 0; btn_right = 0;
      checks++;
      if ({win, dead, score} !== {2'b10, 8'd3}) begin
         failures++;
         $display("FAIL win_result got win,dead,score=%b,%b,%0d want 1,0,3", win, dead, score);
      end
   endtask

   task automatic test_buttons();
      play = 1;
      @(negedge clk);
      btn_left = 1;
      repeat (10) @(negedge clk);
      btn_left = 0;
      @(negedge clk);
      checks++;
      if (player_lane !== 2'd1) begin failures++; $display("FAIL held_left got %0d want 1", player_lane); end
      play = 0;
      @(negedge clk);
      play = 1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         btn_left = 1;
         @(negedge clk);
         btn_left = 0;
         @(negedge clk);
      end
      checks++;
      if (player_lane !== 2'd0) begin failures++; $display("FAIL left_saturate got %0d want 0", player_lane); end
      play = 0;
      @(negedge clk);
      play = 1;
      @(negedge clk);
      btn_left = 1; btn_right = 1;
      @(negedge clk);
      btn_left = 0; btn_right = 0;
      @(negedge clk);
      checks++;
      if (player_lane !== 2'd2) begin failures++; $display("FAIL both_edges got %0d want 2", player_lane); end
      checks++;
      if (dut_out !== m_out()) begin failures++; $display("FAIL model_buttons got %h want %h", dut_out, m_out()); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         checks++;
         if (dut_out !== m_out() || (win && dead)) begin
            failures++;
            $display("FAIL model_random cycle %0d got %h want %h", k, dut_out, m_out());
         end
         play = $urandom_range(63) != 0;
         btn_left = $urandom_range(3) == 0;
         btn_right = $urandom_range(3) == 0;
      end
      btn_left = 0; btn_right = 0;
   endtask

   task automatic test_reset_mid_run();
      play = 0;
      @(negedge clk);
      play = 1;
      repeat (6) @(negedge clk);
      reset = 1; play = 0;
      @(negedge clk);
      checks++;
      if (dut_out !== {2'b00, 2'd2, 16'h0, 8'h0}) begin
         failures++;
         $display("FAIL reset_mid_run got %h want %h", dut_out, {2'b00, 2'd2, 16'h0, 8'h0});
      end
      reset = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_death();
      test_hold("dead");
      test_dodge_win();
      test_hold("won");
      test_buttons();
      test_random();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
